// File: rtl/bf_stage_fx.sv
// Radix-2 single-path delay-feedback DIF butterfly stage with fixed-point scaling,
// a valid-qualified stream, frame marker and sticky twiddle-product saturation flag.
module bf_stage_fx #(
    parameter int N     = 3,
    parameter int n     = 1,
    parameter int W     = 16,
    parameter int TW    = 16,
    parameter int SCALE = 1,
    localparam int OW   = (SCALE != 0) ? W : W + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic signed [W-1:0]  in_re,
    input  logic signed [W-1:0]  in_im,
    output logic [N-2:0]         tw_addr,
    input  logic signed [TW-1:0] tw_re,
    input  logic signed [TW-1:0] tw_im,
    output logic                 out_valid,
    output logic                 out_sof,
    output logic signed [OW-1:0] out_re,
    output logic signed [OW-1:0] out_im,
    output logic                 ovf
);

    localparam int D  = 1 << (N - n);
    localparam int CW = N - n + 1;
    localparam int AW = W + TW + 3;

    localparam logic signed [AW-1:0] OMAX = (AW'(1) <<< (OW - 1)) - AW'(1);
    localparam logic signed [AW-1:0] OMIN = -(AW'(1) <<< (OW - 1));
    localparam logic signed [AW-1:0] RND  = AW'(1) <<< (TW - 2);

    // Stream handshake: in_valid alone qualifies a sample; there is no back-pressure.
    // A cycle with in_valid low leaves counter, delay line and primed untouched.

    logic [CW-1:0]       cnt;
    logic                primed;
    logic                phase_b;
    logic [N-1:0]        cnt_n;

    logic signed [W:0]   dl_re [D];
    logic signed [W:0]   dl_im [D];

    logic signed [W:0]   h_re, h_im, x_re, x_im;
    logic signed [W+1:0] sum_re_w, sum_im_w, diff_re_w, diff_im_w;
    logic signed [W:0]   sum_re_s, sum_im_s, diff_re_s, diff_im_s;
    logic signed [W:0]   push_re, push_im;

    logic signed [AW-1:0] hr_e, hi_e, cr_e, ci_e;
    logic signed [AW-1:0] mr_full, mi_full, mr_r, mi_r;
    logic signed [OW-1:0] mr_o, mi_o;
    logic                 sat_r, sat_i;

    logic signed [OW-1:0] res_re, res_im;

    function automatic logic signed [W:0] scale_fn(input logic signed [W+1:0] v);
        logic signed [W+1:0] r;
        if (SCALE != 0) r = (v + (W+2)'(1)) >>> 1;
        else            r = v;
        return r[W:0];
    endfunction

    // Butterfly datapath: phase A rotates last frame's difference, phase B adds/subtracts.
    always_comb begin
        phase_b   = cnt[CW-1];
        cnt_n     = N'(cnt);
        tw_addr   = phase_b ? '0 : (N-1)'(cnt_n << (n - 1));

        h_re      = dl_re[D-1];
        h_im      = dl_im[D-1];
        x_re      = (W+1)'(in_re);
        x_im      = (W+1)'(in_im);

        sum_re_w  = (W+2)'(h_re) + (W+2)'(x_re);
        sum_im_w  = (W+2)'(h_im) + (W+2)'(x_im);
        diff_re_w = (W+2)'(h_re) - (W+2)'(x_re);
        diff_im_w = (W+2)'(h_im) - (W+2)'(x_im);

        sum_re_s  = scale_fn(sum_re_w);
        sum_im_s  = scale_fn(sum_im_w);
        diff_re_s = scale_fn(diff_re_w);
        diff_im_s = scale_fn(diff_im_w);

        push_re   = phase_b ? diff_re_s : x_re;
        push_im   = phase_b ? diff_im_s : x_im;
    end

    // Full-precision complex multiply, round-half-up to Q(TW-1), saturate to OW.
    always_comb begin
        hr_e    = AW'(h_re);
        hi_e    = AW'(h_im);
        cr_e    = AW'(tw_re);
        ci_e    = AW'(tw_im);
        mr_full = hr_e * cr_e - hi_e * ci_e;
        mi_full = hr_e * ci_e + hi_e * cr_e;
        mr_r    = (mr_full + RND) >>> (TW - 1);
        mi_r    = (mi_full + RND) >>> (TW - 1);

        sat_r = 1'b0;
        mr_o  = OW'(mr_r);
        if (mr_r > OMAX) begin
            sat_r = 1'b1;
            mr_o  = OW'(OMAX);
        end else if (mr_r < OMIN) begin
            sat_r = 1'b1;
            mr_o  = OW'(OMIN);
        end

        sat_i = 1'b0;
        mi_o  = OW'(mi_r);
        if (mi_r > OMAX) begin
            sat_i = 1'b1;
            mi_o  = OW'(OMAX);
        end else if (mi_r < OMIN) begin
            sat_i = 1'b1;
            mi_o  = OW'(OMIN);
        end

        res_re = phase_b ? OW'(sum_re_s) : mr_o;
        res_im = phase_b ? OW'(sum_im_s) : mi_o;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            primed    <= 1'b0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= in_valid & (primed | phase_b);
            out_sof   <= in_valid & (cnt == CW'(D));
            if (in_valid) begin
                cnt    <= cnt + CW'(1);
                out_re <= res_re;
                out_im <= res_im;
                if (cnt == CW'(D - 1))
                    primed <= 1'b1;
                // Only rotations that actually leave the stage count as overflow.
                if (!phase_b && primed && (sat_r || sat_i))
                    ovf <= 1'b1;
            end
        end
    end

    // Delay line contents need no reset: phase-A output is suppressed until primed.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            dl_re[0] <= push_re;
            dl_im[0] <= push_im;
            for (int i = 1; i < D; i++) begin
                dl_re[i] <= dl_re[i-1];
                dl_im[i] <= dl_im[i-1];
            end
        end
    end

endmodule

// File: tb/tb_bf_stage_fx.sv
// Bench for bf_stage_fx (N=3, n=1, W=16, TW=16, SCALE=1): frame-level reference
// model of the radix-2 DIF stage compared against the captured output stream.
module tb_bf_stage_fx;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic signed [15:0] in_re, in_im;
    logic [1:0]         tw_addr;
    logic signed [15:0] tw_re, tw_im;
    logic               out_valid, out_sof;
    logic signed [15:0] out_re, out_im;
    logic               ovf;

    int errors = 0;
    int checks = 0;

    int tw_re_t[4] = '{32767, 23170, 0, -23170};
    int tw_im_t[4] = '{0, -23170, -32767, -23170};

    int xs_re[$], xs_im[$];
    logic signed [15:0] exp_re[$], exp_im[$];
    logic               exp_sof[$];
    logic               exp_ovf;
    logic signed [15:0] got_re[$], got_im[$];
    logic               got_sof[$];
    logic signed [15:0] ref_re[$], ref_im[$];

    bf_stage_fx #(.N(3), .n(1), .W(16), .TW(16), .SCALE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
        .tw_addr(tw_addr), .tw_re(tw_re), .tw_im(tw_im),
        .out_valid(out_valid), .out_sof(out_sof), .out_re(out_re), .out_im(out_im),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    always_comb begin
        tw_re = 16'(tw_re_t[tw_addr]);
        tw_im = 16'(tw_im_t[tw_addr]);
    end

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            got_re.push_back(out_re);
            got_im.push_back(out_im);
            got_sof.push_back(out_sof);
        end
    end

    function automatic int s_fn(int v);
        return (v + 1) >>> 1;
    endfunction

    function automatic longint clamp16(longint v, inout logic o);
        if (v > 32767) begin o = 1'b1; return 32767; end
        if (v < -32768) begin o = 1'b1; return -32768; end
        return v;
    endfunction

    // Frame view: frame f sums appear at c=4..7, its rotated diffs during frame f+1 c=0..3.
    task automatic build_model();
        int f, c, a, b, dr, di;
        longint pr, pi;
        exp_re.delete(); exp_im.delete(); exp_sof.delete();
        exp_ovf = 1'b0;
        for (int g = 0; g < xs_re.size(); g++) begin
            f = g / 8;
            c = g % 8;
            if (c >= 4) begin
                b = f * 8 + c;
                a = b - 4;
                exp_re.push_back(16'(s_fn(xs_re[a] + xs_re[b])));
                exp_im.push_back(16'(s_fn(xs_im[a] + xs_im[b])));
                exp_sof.push_back(c == 4);
            end else if (f >= 1) begin
                a  = (f - 1) * 8 + c;
                dr = s_fn(xs_re[a] - xs_re[a+4]);
                di = s_fn(xs_im[a] - xs_im[a+4]);
                pr = longint'(dr) * tw_re_t[c] - longint'(di) * tw_im_t[c];
                pi = longint'(dr) * tw_im_t[c] + longint'(di) * tw_re_t[c];
                exp_re.push_back(16'(clamp16((pr + 16384) >>> 15, exp_ovf)));
                exp_im.push_back(16'(clamp16((pi + 16384) >>> 15, exp_ovf)));
                exp_sof.push_back(1'b0);
            end
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        got_re.delete(); got_im.delete(); got_sof.delete();
    endtask

    task automatic run_stream(input bit stall);
        for (int i = 0; i < xs_re.size(); i++) begin
            if (stall) begin
                for (int k = 0; k < 3 && $urandom_range(0, 1) == 0; k++) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            in_re = 16'(xs_re[i]);
            in_im = 16'(xs_im[i]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic load_impulse();
        xs_re.delete(); xs_im.delete();
        for (int i = 0; i < 16; i++) begin
            xs_re.push_back(i == 0 ? 1000 : 0);
            xs_im.push_back(0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_re = 16'sd77; in_im = -16'sd5;
        #3;
        checks += 6;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
        if (out_sof !== 1'b0) begin errors++; $display("FAIL reset out_sof: got %b expected 0", out_sof); end
        if (out_re !== 16'sd0) begin errors++; $display("FAIL reset out_re: got %0d expected 0", out_re); end
        if (out_im !== 16'sd0) begin errors++; $display("FAIL reset out_im: got %0d expected 0", out_im); end
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset ovf: got %b expected 0", ovf); end
        if (tw_addr !== 2'd0) begin errors++; $display("FAIL reset tw_addr: got %0d expected 0", tw_addr); end
    endtask

    task automatic test_impulse(input string tag);
        build_model();
        run_stream(1'b0);
        checks++;
        if (got_re.size() != exp_re.size()) begin errors++; $display("FAIL %s count: got %0d expected %0d", tag, got_re.size(), exp_re.size()); end
        for (int i = 0; i < got_re.size() && i < exp_re.size(); i++) begin
            checks++;
            if (got_re[i] !== exp_re[i] || got_im[i] !== exp_im[i] || got_sof[i] !== exp_sof[i]) begin
                errors++;
                $display("FAIL %s[%0d]: got %0d,%0d sof=%b expected %0d,%0d sof=%b", tag, i,
                         got_re[i], got_im[i], got_sof[i], exp_re[i], exp_im[i], exp_sof[i]);
            end
        end
        checks += 4;
        if (got_re.size() < 5 || got_re[0] !== 16'sd500 || got_sof[0] !== 1'b1) begin
            errors++; $display("FAIL %s first_sum: got size %0d expected 500 with sof", tag, got_re.size());
        end
        if (got_re.size() < 5 || got_re[4] !== 16'sd500 || got_im[4] !== 16'sd0) begin
            errors++; $display("FAIL %s diff0: got size %0d expected 500+0j at index 4", tag, got_re.size());
        end
        if (got_re.size() < 2 || got_re[1] !== 16'sd0 || got_sof[1] !== 1'b0) begin
            errors++; $display("FAIL %s second_sum: got size %0d expected 0 without sof", tag, got_re.size());
        end
        if (ovf !== 1'b0) begin errors++; $display("FAIL %s ovf: got %b expected 0", tag, ovf); end
    endtask

    task automatic test_dc();
        reset_dut();
        xs_re.delete(); xs_im.delete();
        for (int i = 0; i < 16; i++) begin xs_re.push_back(1000); xs_im.push_back(0); end
        build_model();
        run_stream(1'b0);
        checks++;
        if (got_re.size() != 12) begin errors++; $display("FAIL dc count: got %0d expected 12", got_re.size()); end
        for (int i = 0; i < got_re.size() && i < exp_re.size(); i++) begin
            checks++;
            if (got_re[i] !== exp_re[i] || got_im[i] !== exp_im[i] ||
                got_re[i] !== ((i % 8) < 4 ? 16'sd1000 : 16'sd0)) begin
                errors++;
                $display("FAIL dc[%0d]: got %0d,%0d expected %0d,%0d", i, got_re[i], got_im[i], exp_re[i], exp_im[i]);
            end
        end
    endtask

    task automatic test_rounding();
        for (int s = 0; s < 2; s++) begin
            reset_dut();
            xs_re.delete(); xs_im.delete();
            for (int i = 0; i < 16; i++) begin
                xs_re.push_back(i == 0 ? (s == 0 ? 1 : -1) : 0);
                xs_im.push_back(0);
            end
            build_model();
            run_stream(1'b0);
            checks += 2;
            if (got_re.size() < 5 || got_re[0] !== (s == 0 ? 16'sd1 : 16'sd0)) begin
                errors++; $display("FAIL round%0d sum: got %0d expected %0d", s, got_re.size() > 0 ? got_re[0] : 16'sd0, s == 0 ? 1 : 0);
            end
            if (got_re.size() < 5 || got_re[4] !== exp_re[4] || exp_re[4] !== (s == 0 ? 16'sd1 : 16'sd0)) begin
                errors++; $display("FAIL round%0d diff: got %0d expected %0d", s, got_re.size() > 4 ? got_re[4] : 16'sd0, s == 0 ? 1 : 0);
            end
        end
    endtask

    task automatic test_saturation();
        reset_dut();
        xs_re.delete(); xs_im.delete();
        for (int i = 0; i < 16; i++) begin
            xs_re.push_back(i == 1 ? 32767 : (i == 5 ? -32767 : 0));
            xs_im.push_back(i == 1 ? -32767 : (i == 5 ? 32767 : 0));
        end
        build_model();
        run_stream(1'b0);
        checks += 3;
        if (got_re.size() < 6 || got_re[5] !== 16'sd0 || got_im[5] !== -16'sd32768) begin
            errors++; $display("FAIL sat value: got size %0d, expected 0-32768j at index 5", got_re.size());
        end
        if (got_re.size() >= 6 && (got_re[5] !== exp_re[5] || got_im[5] !== exp_im[5])) begin
            errors++; $display("FAIL sat model: got %0d,%0d expected %0d,%0d", got_re[5], got_im[5], exp_re[5], exp_im[5]);
        end
        if (ovf !== 1'b1 || exp_ovf !== 1'b1) begin errors++; $display("FAIL sat ovf: got %b expected 1", ovf); end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_re = '0; in_im = '0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL sat ovf_sticky: got %b expected 1", ovf); end
    endtask

    task automatic test_stall();
        reset_dut();
        xs_re.delete(); xs_im.delete();
        for (int i = 0; i < 32; i++) begin
            xs_re.push_back(int'($urandom_range(0, 65535)) - 32768);
            xs_im.push_back(int'($urandom_range(0, 65535)) - 32768);
        end
        build_model();
        run_stream(1'b0);
        ref_re = got_re; ref_im = got_im;
        reset_dut();
        run_stream(1'b1);
        checks += 2;
        if (got_re.size() != exp_re.size()) begin errors++; $display("FAIL stall count: got %0d expected %0d", got_re.size(), exp_re.size()); end
        if (ovf !== exp_ovf) begin errors++; $display("FAIL stall ovf: got %b expected %b", ovf, exp_ovf); end
        for (int i = 0; i < got_re.size() && i < exp_re.size(); i++) begin
            checks++;
            if (got_re[i] !== exp_re[i] || got_im[i] !== exp_im[i] || got_sof[i] !== exp_sof[i]) begin
                errors++;
                $display("FAIL stall[%0d]: got %0d,%0d expected %0d,%0d", i, got_re[i], got_im[i], exp_re[i], exp_im[i]);
            end
        end
        for (int i = 0; i < got_re.size() && i < ref_re.size(); i++) begin
            checks++;
            if (got_re[i] !== ref_re[i] || got_im[i] !== ref_im[i]) begin
                errors++;
                $display("FAIL stall_vs_cont[%0d]: got %0d,%0d continuous %0d,%0d", i, got_re[i], got_im[i], ref_re[i], ref_im[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_re = 16'($urandom_range(0, 65535));
            in_im = 16'($urandom_range(0, 65535));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #2;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst out_valid: got %b expected 0", out_valid); end
        if (tw_addr !== 2'd0) begin errors++; $display("FAIL midrst tw_addr: got %0d expected 0", tw_addr); end
        rst = 1'b0;
        @(posedge clk); #1;
        got_re.delete(); got_im.delete(); got_sof.delete();
        load_impulse();
        test_impulse("midrst_impulse");
    endtask

    initial begin
        test_reset();
        reset_dut();
        load_impulse();
        test_impulse("impulse");
        test_dc();
        test_rounding();
        test_saturation();
        test_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
